// File: rtl/tick_key_debounce_pkg.sv
// Shared definitions for the tick-sampled key debouncer.
//   SYNC_DEPTH : number of flops in the key input synchronizer
//   state_t    : 2-bit debouncer state with its four encodings
package tick_key_debounce_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE         = 2'd0;
    localparam state_t ST_PRESS_WAIT   = 2'd1;
    localparam state_t ST_HELD         = 2'd2;
    localparam state_t ST_RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/tick_key_debounce_if.sv
// Key debouncer signal bundle.
//   tick_in     : one-cycle sampling strobe from the tick counter
//   key_in      : raw key pin
//   key_level   : debounced key state, 1 = pressed
//   key_press   : one-cycle pulse when a press is accepted
//   key_release : one-cycle pulse when a release is accepted
//   long_press  : one-cycle pulse once per press after the long hold time
interface tick_key_debounce_if;

    logic tick_in;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic long_press;

    modport master (
        output tick_in, key_in,
        input  key_level, key_press, key_release, long_press
    );

    modport slave (
        input  tick_in, key_in,
        output key_level, key_press, key_release, long_press
    );

endinterface

// File: rtl/tick_key_debounce_sync_2ff.sv
// Single-bit multi-flop synchronizer for an asynchronous board pin.
//   clk : destination clock
//   rst : asynchronous active-high reset, flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output
module sync_2ff
    import tick_key_debounce_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] sr;

    // Shift chain; q is the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {SYNC_DEPTH{RST_VAL}};
        end else begin
            sr <= {sr[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = sr[SYNC_DEPTH-1];

endmodule

// File: rtl/tick_key_debounce.sv
// Tick-sampled key debouncer with press, release and long-press events.
//   clk_in : system clock, rising edge
//   rst_in : asynchronous active-high reset
//   bus    : tick_key_debounce_if.slave (tick/key in, level and pulses out)
module tick_key_debounce
    import tick_key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned LONG_TICKS   = 100,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    tick_key_debounce_if.slave  bus
);

    localparam int unsigned SW = $clog2(STABLE_TICKS);
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

    logic          sync_q;
    logic          key_act;

    state_t        state_q,   state_d;
    logic [SW-1:0] stab_q,    stab_d;
    logic [HW-1:0] hold_q,    hold_d;
    logic          level_q,   level_d;
    logic          press_q,   press_d;
    logic          release_q, release_d;
    logic          long_q,    long_d;

    // Reset the synchronizer to the released pin level so a key held
    // through reset still has to qualify from scratch
    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk_in),
        .rst (rst_in),
        .d   (bus.key_in),
        .q   (sync_q)
    );

    assign key_act = sync_q ^ ACTIVE_LOW;

    // State and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            stab_q    <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // Next-state logic; only tick cycles advance, pulses clear otherwise
    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        if (bus.tick_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_act) begin
                        state_d = ST_PRESS_WAIT;
                        stab_d  = SW'(1);
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!key_act) begin
                        state_d = ST_IDLE;
                        stab_d  = '0;
                    end else if (stab_q == STAB_LAST) begin
                        state_d = ST_HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        stab_d  = '0;
                        hold_d  = '0;
                    end else begin
                        stab_d = stab_q + SW'(1);
                    end
                end
                ST_HELD: begin
                    if (key_act) begin
                        // Saturate so long_press can only fire once per press
                        if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + HW'(1);
                            long_d = (hold_q == (HOLD_MAX - HW'(1)));
                        end
                    end else begin
                        state_d = ST_RELEASE_WAIT;
                        stab_d  = SW'(1);
                    end
                end
                ST_RELEASE_WAIT: begin
                    // hold_q is kept across release bounce
                    if (key_act) begin
                        state_d = ST_HELD;
                        stab_d  = '0;
                    end else if (stab_q == STAB_LAST) begin
                        state_d   = ST_IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        stab_d    = '0;
                        hold_d    = '0;
                    end else begin
                        stab_d = stab_q + SW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.key_level   = level_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.long_press  = long_q;

endmodule

// File: tb/tb_tick_key_debounce.sv
// Self-checking bench for tick_key_debounce against a run-length model.
module tb_tick_key_debounce;

    localparam int unsigned STABLE  = 4;
    localparam int unsigned LONG    = 100;
    localparam bit          ACT_LOW = 1'b1;

    logic clk = 1'b0;
    logic rst;

    tick_key_debounce_if dut_if ();

    tick_key_debounce #(
        .STABLE_TICKS (STABLE),
        .LONG_TICKS   (LONG),
        .ACTIVE_LOW   (ACT_LOW)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (dut_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accepted level flips once STABLE consecutive ticks
    // disagree with it; hold counts agreeing pressed ticks that are not
    // recoveries from a release bounce.
    int m_level;
    int m_run;
    int m_hold;
    bit h0, h1;
    bit e_press, e_rel, e_long;

    int press_cnt, rel_cnt, long_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0;
        m_run   = 0;
        m_hold  = 0;
        h0      = 1'b0;
        h1      = 1'b0;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
    endtask

    task automatic clr_cnt();
        press_cnt = 0;
        rel_cnt   = 0;
        long_cnt  = 0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".key_level"},   32'(dut_if.key_level),   32'(m_level));
        check({tag, ".key_press"},   32'(dut_if.key_press),   32'(e_press));
        check({tag, ".key_release"}, 32'(dut_if.key_release), 32'(e_rel));
        check({tag, ".long_press"},  32'(dut_if.long_press),  32'(e_long));
    endtask

    // One clock: drive tick and pressed-state, advance model, compare
    task automatic step(input bit t, input bit a);
        bit used;
        dut_if.tick_in = t;
        dut_if.key_in  = a ^ ACT_LOW;
        @(posedge clk);
        // Decision uses the pin value seen two edges earlier
        used    = h1;
        h1      = h0;
        h0      = a;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        if (t) begin
            if (int'(used) == m_level) begin
                if (m_level == 1 && m_run == 0 && m_hold < LONG) begin
                    m_hold++;
                    if (m_hold == LONG) e_long = 1'b1;
                end
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == STABLE) begin
                    m_level = int'(used);
                    m_run   = 0;
                    m_hold  = 0;
                    if (used) e_press = 1'b1;
                    else      e_rel   = 1'b1;
                end
            end
        end
        @(negedge clk);
        check_outs("step");
        if (dut_if.key_press)   press_cnt++;
        if (dut_if.key_release) rel_cnt++;
        if (dut_if.long_press)  long_cnt++;
    endtask

    task automatic run_ticks(input int n, input bit a, input int period);
        repeat (n) begin
            repeat (period - 1) step(1'b0, a);
            step(1'b1, a);
        end
    endtask

    initial begin
        bit ract;
        rst            = 1'b1;
        dut_if.tick_in = 1'b0;
        dut_if.key_in  = 1'b1 ^ ACT_LOW;
        model_reset();
        clr_cnt();
        #1;
        check_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Key held through reset must qualify over four ticks
        run_ticks(3, 1'b1, 10);
        check("press_before_4th", 32'(press_cnt), 32'd0);
        run_ticks(1, 1'b1, 10);
        check("press_at_4th", 32'(press_cnt), 32'd1);
        check("level_after_press", 32'(dut_if.key_level), 32'd1);

        // Long hold: long_press exactly on the 100th held tick
        clr_cnt();
        run_ticks(99, 1'b1, 10);
        check("long_before_100", 32'(long_cnt), 32'd0);
        run_ticks(1, 1'b1, 10);
        check("long_at_100", 32'(long_cnt), 32'd1);
        run_ticks(50, 1'b1, 10);
        check("long_once", 32'(long_cnt), 32'd1);
        check("press_once", 32'(press_cnt), 32'd0);

        // No ticks: pin chatter must not change anything
        clr_cnt();
        for (int i = 0; i < 1000; i++) step(1'b0, 1'($urandom_range(0, 1)));
        check("idle_events", 32'(press_cnt + rel_cnt + long_cnt), 32'd0);
        check("idle_level", 32'(dut_if.key_level), 32'd1);

        // Release, then bouncy press 2 on / 1 off / 4 on
        clr_cnt();
        run_ticks(4, 1'b0, 10);
        check("release_once", 32'(rel_cnt), 32'd1);
        clr_cnt();
        run_ticks(2, 1'b1, 10);
        run_ticks(1, 1'b0, 10);
        run_ticks(3, 1'b1, 10);
        check("bounce_no_press", 32'(press_cnt), 32'd0);
        run_ticks(1, 1'b1, 10);
        check("bounce_press", 32'(press_cnt), 32'd1);

        // 60 held, release bounce 3 off / 1 on / 4 off, then fresh press
        clr_cnt();
        run_ticks(60, 1'b1, 10);
        run_ticks(3, 1'b0, 10);
        run_ticks(1, 1'b1, 10);
        run_ticks(3, 1'b0, 10);
        check("rel_bounce_none", 32'(rel_cnt), 32'd0);
        run_ticks(1, 1'b0, 10);
        check("rel_bounce_once", 32'(rel_cnt), 32'd1);
        check("rel_level", 32'(dut_if.key_level), 32'd0);
        check("no_long_60", 32'(long_cnt), 32'd0);
        clr_cnt();
        run_ticks(4, 1'b1, 10);
        check("repress", 32'(press_cnt), 32'd1);
        run_ticks(40, 1'b1, 10);
        check("no_long_40", 32'(long_cnt), 32'd0);

        // Asynchronous reset while held
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_outs("in_reset");
        rst = 1'b0;
        clr_cnt();
        run_ticks(3, 1'b1, 10);
        check("post_rst_no_press", 32'(press_cnt), 32'd0);
        run_ticks(1, 1'b1, 10);
        check("post_rst_press", 32'(press_cnt), 32'd1);

        // Back-to-back ticks: every cycle counts
        run_ticks(10, 1'b0, 1);
        clr_cnt();
        run_ticks(150, 1'b1, 1);
        check("b2b_press", 32'(press_cnt), 32'd1);
        check("b2b_long", 32'(long_cnt), 32'd1);

        // Random chatter and tick spacing
        ract = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) ract = ~ract;
            step(($urandom_range(0, 2) == 0), ract);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
